// File: rtl/unprojector_pkg.sv
// Shared screen/view-space vertex types and projection constants, kept common
// with the forward projector so both directions agree on the camera model.
package unprojector_pkg;

   localparam int SCREEN_CX    = 320;
   localparam int SCREEN_CY    = 240;
   localparam int FOCAL_LENGTH = 400;
   localparam int Z_OFFSET     = 400;

   typedef struct packed {
      logic        [9:0] x;
      logic        [9:0] y;
      logic signed [9:0] z;
   } vertex_2d_t;

   typedef struct packed {
      logic signed [9:0] x;
      logic signed [9:0] y;
      logic signed [9:0] z;
   } vertex_3d_t;

endpackage

// File: rtl/unprojector_udiv_iter.sv
// Unsigned restoring divider, one quotient bit per clock. Dividend bits are
// shifted out of the quotient register as quotient bits shift in.
module udiv_iter #(
   parameter int unsigned W = 20
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int unsigned CW = $clog2(W + 1);

   logic [W-1:0]  rem_q, rem_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  dvs_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W:0]    shift;
   logic [W:0]    diff;
   logic          ge;

   always_comb begin
      shift = {rem_q, quo_q[W-1]};
      diff  = shift - {1'b0, dvs_q};
      ge    = shift >= {1'b0, dvs_q};
      rem_d = rem_q;
      quo_d = quo_q;
      cnt_d = cnt_q;
      if (cnt_q != '0) begin
         rem_d = W'(ge ? diff : shift);
         quo_d = {quo_q[W-2:0], ge};
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
         cnt_q <= CW'(W);
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_d;
      end
   end

   assign busy     = (cnt_q != '0);
   assign done     = (cnt_q == CW'(1));
   assign quotient = quo_q;

endmodule

// File: rtl/unprojector.sv
// Screen-space to view-space unprojection: x' = (x-cx)*(z+zoff)/f, same for y,
// with sign-magnitude division so results truncate toward zero.
module unprojector
   import unprojector_pkg::vertex_2d_t, unprojector_pkg::vertex_3d_t;
#(
   parameter int FOCAL_LENGTH = unprojector_pkg::FOCAL_LENGTH,
   parameter int Z_OFFSET     = unprojector_pkg::Z_OFFSET,
   parameter int CENTER_X     = unprojector_pkg::SCREEN_CX,
   parameter int CENTER_Y     = unprojector_pkg::SCREEN_CY,
   parameter int QUOT_W       = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  vertex_2d_t in_v,
   output logic       out_valid,
   input  logic       out_ready,
   output vertex_3d_t out_v,
   output logic       out_err,
   output logic       out_sat
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e            state_q, state_d;
   vertex_2d_t        vtx_q, vtx_d;
   logic              err_q, err_d;
   logic              negx_q, negx_d;
   logic              negy_q, negy_d;
   logic              div_load;

   logic signed [10:0] dx, dy;
   logic signed [11:0] zd;
   logic signed [22:0] px, py;
   logic        [22:0] ax, ay;
   logic [QUOT_W-1:0]  mag_x, mag_y, qx, qy;
   logic               x_busy, y_busy, x_done, y_done;
   logic [10:0]        rx, ry;

   // Returns {clipped, value} for a sign-magnitude quotient clamped to [-512, 511].
   function automatic logic [10:0] sat_axis(input logic neg, input logic [QUOT_W-1:0] mag);
      if (!neg) begin
         if (mag > QUOT_W'(511)) return {1'b1, 10'h1FF};
         return {1'b0, mag[9:0]};
      end
      if (mag > QUOT_W'(512)) return {1'b1, 10'h200};
      return {1'b0, 10'(~mag[9:0] + 10'd1)};
   endfunction

   always_comb begin
      dx    = $signed({1'b0, vtx_q.x}) - 11'(CENTER_X);
      dy    = $signed({1'b0, vtx_q.y}) - 11'(CENTER_Y);
      zd    = {{2{vtx_q.z[9]}}, vtx_q.z} + 12'(Z_OFFSET);
      px    = 23'(dx) * 23'(zd);
      py    = 23'(dy) * 23'(zd);
      ax    = px[22] ? 23'(-px) : px;
      ay    = py[22] ? 23'(-py) : py;
      mag_x = QUOT_W'(ax);
      mag_y = QUOT_W'(ay);
   end

   udiv_iter #(.W(QUOT_W)) u_div_x (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (div_load),
      .dividend (mag_x),
      .divisor  (QUOT_W'(FOCAL_LENGTH)),
      .busy     (x_busy),
      .done     (x_done),
      .quotient (qx)
   );

   udiv_iter #(.W(QUOT_W)) u_div_y (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (div_load),
      .dividend (mag_y),
      .divisor  (QUOT_W'(FOCAL_LENGTH)),
      .busy     (y_busy),
      .done     (y_done),
      .quotient (qy)
   );

   always_comb begin
      state_d  = state_q;
      vtx_d    = vtx_q;
      err_d    = err_q;
      negx_d   = negx_q;
      negy_d   = negy_q;
      div_load = 1'b0;
      unique case (state_q)
         S_IDLE: if (in_valid) begin
            vtx_d   = in_v;
            err_d   = 1'b0;
            state_d = S_MUL;
         end
         S_MUL: if (zd <= 12'sd0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
         end else begin
            negx_d   = px[22];
            negy_d   = py[22];
            div_load = 1'b1;
            state_d  = S_DIV;
         end
         // The idle-divider exit only guards against a stuck DIV state.
         S_DIV: if ((x_done && y_done) || !(x_busy || y_busy)) state_d = S_DONE;
         S_DONE: if (out_ready) begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         vtx_q   <= '0;
         err_q   <= 1'b0;
         negx_q  <= 1'b0;
         negy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vtx_q   <= vtx_d;
         err_q   <= err_d;
         negx_q  <= negx_d;
         negy_q  <= negy_d;
      end
   end

   always_comb begin
      rx        = sat_axis(negx_q, qx);
      ry        = sat_axis(negy_q, qy);
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      out_v     = '0;
      out_err   = 1'b0;
      out_sat   = 1'b0;
      if (state_q == S_DONE) begin
         out_v.z = vtx_q.z;
         out_err = err_q;
         if (!err_q) begin
            out_v.x = rx[9:0];
            out_v.y = ry[9:0];
            out_sat = rx[10] | ry[10];
         end
      end
   end

endmodule

// File: tb/tb_unprojector.sv
// Randomized and directed bench for unprojector against an integer-arithmetic
// reference of the unprojection formula.
module tb_unprojector;
   import unprojector_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   vertex_2d_t in_v = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   vertex_3d_t out_v;
   logic       out_err;
   logic       out_sat;

   int unsigned tests = 0;
   int unsigned fails = 0;

   int  exp_x, exp_y, exp_z;
   bit  exp_err, exp_sat;
   bit  exp_armed = 1'b0;

   always #5 clk = ~clk;

   unprojector #(
      .FOCAL_LENGTH (400),
      .Z_OFFSET     (400),
      .CENTER_X     (320),
      .CENTER_Y     (240),
      .QUOT_W       (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_v      (in_v),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_v     (out_v),
      .out_err   (out_err),
      .out_sat   (out_sat)
   );

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int clamp(input int v, output bit clipped);
      clipped = (v > 511) || (v < -512);
      if (v > 511) return 511;
      if (v < -512) return -512;
      return v;
   endfunction

   // SV integer division truncates toward zero, matching the required rounding.
   task automatic model(input int x, input int y, input int z,
                        output int rx, output int ry, output bit err, output bit sat);
      int  zdist;
      bit  cx, cy;
      zdist = z + 400;
      err = (zdist <= 0);
      sat = 1'b0;
      rx = 0;
      ry = 0;
      if (!err) begin
         rx  = clamp(((x - 320) * zdist) / 400, cx);
         ry  = clamp(((y - 240) * zdist) / 400, cy);
         sat = cx | cy;
      end
   endtask

   task automatic pin(input int x, input int y, input int z,
                      input int lx, input int ly, input bit lerr, input bit lsat);
      int rx, ry;
      bit e, s;
      model(x, y, z, rx, ry, e, s);
      chk("model_x", rx, lx);
      chk("model_y", ry, ly);
      chk("model_err", int'(e), int'(lerr));
      chk("model_sat", int'(s), int'(lsat));
   endtask

   // Every cycle a result is presented it must match the pending expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (!exp_armed) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            chk("out_x", int'($signed(out_v.x)), exp_x);
            chk("out_y", int'($signed(out_v.y)), exp_y);
            chk("out_z", int'($signed(out_v.z)), exp_z);
            chk("out_err", int'(out_err), int'(exp_err));
            chk("out_sat", int'(out_sat), int'(exp_sat));
            chk("in_ready_in_done", int'(in_ready), 0);
         end
      end
   end

   task automatic transact(input int x, input int y, input int z, input int hold);
      int n;
      int rx, ry;
      bit e, s;
      model(x, y, z, rx, ry, e, s);
      exp_x = rx; exp_y = ry; exp_z = z; exp_err = e; exp_sat = s;
      exp_armed = 1'b1;
      @(negedge clk);
      in_v.x = 10'(x); in_v.y = 10'(y); in_v.z = 10'(z);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      forever begin
         out_ready = 1'($urandom);
         @(posedge clk);
         n++;
         #1;
         if (out_valid || n > 60) break;
      end
      chk("latency", n, e ? 1 : 21);
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid = 1'($urandom);
         in_v = vertex_2d_t'($urandom);
         @(posedge clk);
         #1;
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_in_ready", int'(in_ready), 0);
      end
      // A vertex offered on the release edge must not be captured.
      in_valid = 1'b1;
      in_v = vertex_2d_t'($urandom);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      exp_armed = 1'b0;
      chk("release_valid", int'(out_valid), 0);
      chk("release_in_ready", int'(in_ready), 1);
   endtask

   initial begin
      pin(320, 240,    0,    0,    0, 1'b0, 1'b0);
      pin(420, 140,    0,  100, -100, 1'b0, 1'b0);
      pin(639, 479,  100,  398,  298, 1'b0, 1'b0);
      pin(  0,   0, -100, -240, -180, 1'b0, 1'b0);
      pin(639, 240,  511,  511,    0, 1'b0, 1'b1);
      pin(  0, 240,  511, -512,    0, 1'b0, 1'b1);
      pin(  5,   5, -400,    0,    0, 1'b1, 1'b0);

      #12;
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_v", int'(out_v), 0);
      chk("reset_flags", int'({out_err, out_sat}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      transact(320, 240,    0, 0);
      transact(420, 140,    0, 0);
      transact(639, 479,  100, 1);
      transact(  0,   0, -100, 0);
      transact(639, 240,  511, 2);
      transact(  0, 240,  511, 0);
      transact( 77, 901, -400, 0);
      transact(1023, 1023, -512, 0);
      transact(1023, 1023,  511, 0);
      transact(320, 240,    0, 5);
      transact(100, 400,   -7, 0);

      // Reset during the 10th divide iteration discards the partial result.
      @(negedge clk);
      in_v.x = 10'd100; in_v.y = 10'd100; in_v.z = 10'sd50;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_in_ready", int'(in_ready), 1);
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_out_v", int'(out_v), 0);
      @(negedge clk);
      rst_n = 1'b1;
      transact(420, 140, 0, 0);

      for (int i = 0; i < 30; i++) begin
         transact(int'($urandom_range(1023)), int'($urandom_range(1023)),
                  int'($urandom_range(1023)) - 512, int'($urandom_range(3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
